fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 139 +++++++++++++
 tb/tb_fetch_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: streams bytes from memory through a
// two-entry buffer, with flush/redirect and a halt/wakeup state.
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wakeup,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        term_issued,
  input  logic [15:0] term_next_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] pc;
  logic [15:0] pc_nx;
  logic [1:0]  count;
  logic [1:0]  count_nx;
  logic        inflight;
  logic        inflight_nx;
  logic [7:0]  head;
  logic [7:0]  head_nx;
  logic [7:0]  tail;
  logic [7:0]  tail_nx;

  logic        fetching;
  logic        flush;
  logic        pop;
  logic        push;
  logic [2:0]  occ;

  assign fetching    = (state == FETCH);
  assign flush       = redirect_valid | (term_issued & fetching);
  assign instr_valid = (count != 2'd0);
  assign instr       = head;
  assign halted      = (state == HALT);
  assign mem_addr    = pc;
  assign pop         = instr_valid & instr_ready;

  // Occupancy once the outstanding read lands, net of this cycle's pop.
  assign occ = {1'b0, count}
             + {2'b00, inflight}
             - {2'b00, pop};

  assign mem_req = fetching & ~flush & (occ < 3'd2);

  // Only responses to our own requests are accepted; this also drops
  // the stray response in the first cycle after reset.
  assign push = mem_rvalid & inflight & ~flush
              & ((count != 2'd2) | pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (term_issued) state_nx = HALT;
      HALT:  if (wakeup)      state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    pc_nx = pc;
    if (redirect_valid) begin
      pc_nx = redirect_pc;
    end else if (term_issued & fetching) begin
      pc_nx = term_next_pc;
    end else if (mem_req) begin
      pc_nx = pc + 16'd1;
    end
  end

  assign inflight_nx = mem_req;

  always_comb begin
    count_nx = count;
    head_nx  = head;
    tail_nx  = tail;
    if (flush) begin
      count_nx = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_nx = mem_rdata;
          else               tail_nx = mem_rdata;
          count_nx = count + 2'd1;
        end
        2'b01: begin
          head_nx  = tail;
          count_nx = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_nx = mem_rdata;
          end else begin
            head_nx = tail;
            tail_nx = mem_rdata;
          end
        end
        default: begin
          count_nx = count;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      count    <= 2'd0;
      inflight <= 1'b0;
      head     <= 8'h00;
      tail     <= 8'h00;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      count    <= count_nx;
      inflight <= inflight_nx;
      head     <= head_nx;
      tail     <= tail_nx;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized scoreboard bench for fetch_seq: expected fetch addresses
// and delivered bytes are queued per sequential segment.
module tb_fetch_seq;

  localparam logic [15:0] RESET_PC = 16'h0200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wakeup;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        term_issued;
  logic [15:0] term_next_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_seq #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .wakeup(wakeup),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .term_issued(term_issued),
    .term_next_pc(term_next_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .halted(halted)
  );

  logic [7:0] mem [0:65535];

  // Fixed one-cycle latency memory that never stalls.
  always @(posedge clk) begin
    mem_rvalid <= mem_req;
    mem_rdata  <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit mon_on = 1'b0;
  bit mdl_halt = 1'b0;
  logic [15:0] nxt_f;
  logic [15:0] nxt_d;
  logic [15:0] fq[$];
  logic [7:0]  dq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void seg(input logic [15:0] a);
    fq.delete();
    dq.delete();
    nxt_f = a;
    nxt_d = a;
  endfunction

  function automatic void refill();
    while (fq.size() < 4) begin
      fq.push_back(nxt_f);
      nxt_f = nxt_f + 16'd1;
    end
    while (dq.size() < 4) begin
      dq.push_back(mem[nxt_d]);
      nxt_d = nxt_d + 16'd1;
    end
  endfunction

  // Model update from the inputs held during the cycle that just ended.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mdl_halt = 1'b0;
      seg(RESET_PC);
    end else if (!mdl_halt && term_issued) begin
      mdl_halt = 1'b1;
      seg(redirect_valid ? redirect_pc : term_next_pc);
    end else if (redirect_valid) begin
      seg(redirect_pc);
    end else if (mdl_halt && wakeup) begin
      mdl_halt = 1'b0;
    end
    refill();
    mon_on = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("halted", {31'd0, halted}, {31'd0, mdl_halt});
      if (mdl_halt) chk("req_in_halt", {31'd0, mem_req}, 32'd0);
      if (mem_req === 1'b1) begin
        if (fq.size() == 0) chk("fetch_q_empty", 32'd1, 32'd0);
        else chk("fetch_addr", {16'd0, mem_addr}, {16'd0, fq.pop_front()});
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        delivered++;
        if (dq.size() == 0) chk("instr_q_empty", 32'd1, 32'd0);
        else chk("instr", {24'd0, instr}, {24'd0, dq.pop_front()});
      end
    end
  end

  initial begin
    bit got;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0200] = 8'hA9;
    mem[16'h0201] = 8'h05;
    mem[16'h0202] = 8'h00;
    rst = 1'b1;
    wakeup = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    term_issued = 1'b0;
    term_next_pc = 16'h0000;
    instr_ready = 1'b1;

    tick();
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("c1_req", {31'd0, mem_req}, 32'd1);
    chk("c1_addr", {16'd0, mem_addr}, 32'h0200);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("c2_addr", {16'd0, mem_addr}, 32'h0201);
    tick();
    @(negedge clk);
    chk("c3_addr", {16'd0, mem_addr}, 32'h0202);
    chk("c3_instr", {23'd0, instr_valid, instr}, 32'h1A9);
    tick();
    @(negedge clk);
    chk("c4_instr", {23'd0, instr_valid, instr}, 32'h105);
    tick();
    @(negedge clk);
    chk("c5_instr", {23'd0, instr_valid, instr}, 32'h100);
    tick();

    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("bp_req", {31'd0, mem_req}, 32'd0);
    chk("bp_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stream", {31'd0, instr_valid}, 32'd1);
      tick();
    end

    term_issued = 1'b1;
    term_next_pc = 16'h0310;
    @(negedge clk);
    tick();
    term_issued = 1'b0;
    @(negedge clk);
    chk("term_valid", {31'd0, instr_valid}, 32'd0);
    chk("term_halted", {31'd0, halted}, 32'd1);
    chk("term_req", {31'd0, mem_req}, 32'd0);
    tick();
    @(negedge clk);
    tick();
    wakeup = 1'b1;
    @(negedge clk);
    tick();
    wakeup = 1'b0;
    @(negedge clk);
    chk("wake_req", {31'd0, mem_req}, 32'd1);
    chk("wake_addr", {16'd0, mem_addr}, 32'h0310);
    tick();

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h8000;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("redir_got", {31'd0, got}, 32'd1);
    if (got) chk("redir_first", {24'd0, instr}, {24'd0, mem[16'h8000]});
    tick();

    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_a", {15'd0, mem_req, mem_addr}, 32'h1FFFF);
    tick();
    @(negedge clk);
    chk("wrap_b", {15'd0, mem_req, mem_addr}, 32'h10000);
    tick();

    term_issued = 1'b1;
    term_next_pc = 16'h0555;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    @(negedge clk);
    tick();
    term_issued = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("both_halted", {31'd0, halted}, 32'd1);
    chk("both_pc", {16'd0, mem_addr}, 32'h1234);
    tick();
    wakeup = 1'b1;
    @(negedge clk);
    tick();
    wakeup = 1'b0;
    @(negedge clk);
    chk("both_wake", {15'd0, mem_req, mem_addr}, 32'h11234);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_halted", {31'd0, halted}, 32'd0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_pc", {16'd0, mem_addr}, 32'h0200);
    tick();

    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 40) == 0);
      redirect_pc = 16'($urandom);
      term_issued = ($urandom_range(0, 40) == 0);
      term_next_pc = 16'($urandom);
      wakeup = ($urandom_range(0, 4) == 0) && !(mdl_halt && redirect_valid);
      rst = ($urandom_range(0, 500) == 0);
      @(negedge clk);
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    term_issued = 1'b0;
    wakeup = 1'b0;
    @(negedge clk);
    chk("throughput", {31'd0, delivered > 500}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
